vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 130 +++++++++++++
 tb/tb_vga_timing.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// VGA raster timing: h/v counters, sync/blank generation and registered colour output.
// Define VGA_TIMING_PIPE_ALIGN_EN to delay hsync_n/vsync_n/blank_n by PIPE_LAT+1 clocks so they line up with the colour.
module vga_timing #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned PIPE_LAT  = 2
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  input  logic [23:0] vga_in,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        blank_n,
  output logic        next_frame,
  output logic [7:0]  frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_FRAME   = 10'(V_VISIBLE);
  // 11-bit bounds so an end value of exactly 1024 still compares correctly
  localparam logic [10:0] H_ACT_END = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_ACT_END = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam int DEPTH = int'(PIPE_LAT) + 1;

  logic [9:0] h;
  logic [9:0] v;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       frame_start_nxt;

  assign x_pos = h;
  assign y_pos = v;

  always_comb begin
    h_nxt = h + 10'd1;
    v_nxt = v;
    if (h == H_LAST) begin
      h_nxt = 10'd0;
      v_nxt = (v == V_LAST) ? 10'd0 : v + 10'd1;
    end
  end

  // next_frame is registered from the next counter values so it is high in the same clock as h==0, v==V_VISIBLE
  assign frame_start_nxt = (h_nxt == 10'd0) && (v_nxt == V_FRAME);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h           <= 10'd0;
      v           <= 10'd0;
      next_frame  <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      h          <= h_nxt;
      v          <= v_nxt;
      next_frame <= frame_start_nxt;
      if (frame_start_nxt) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  logic hs_raw;
  logic vs_raw;
  logic act_raw;

  assign hs_raw  = ({1'b0, h} >= HS_START) && ({1'b0, h} < HS_END);
  assign vs_raw  = ({1'b0, v} >= VS_START) && ({1'b0, v} < VS_END);
  assign act_raw = ({1'b0, h} < H_ACT_END) && ({1'b0, v} < V_ACT_END);

  // Stage i holds {hsync_n, vsync_n, blank} delayed i+1 clocks
  logic [2:0] sync_q [DEPTH];

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        sync_q[i] <= 3'b110;
      end
    end else begin
      sync_q[0] <= {~hs_raw, ~vs_raw, act_raw};
      for (int i = 1; i < DEPTH; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  logic gate;

`ifdef VGA_TIMING_PIPE_ALIGN_EN
  if (PIPE_LAT == 0) begin : g_gate_raw
    assign gate = act_raw;
  end else begin : g_gate_pipe
    assign gate = sync_q[PIPE_LAT-1][0];
  end
  assign {hsync_n, vsync_n, blank_n} = sync_q[DEPTH-1];
`else
  assign gate = sync_q[0][0];
  assign {hsync_n, vsync_n, blank_n} = sync_q[0];
`endif

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      {vga_r, vga_g, vga_b} <= 24'd0;
    end else if (gate) begin
      {vga_r, vga_g, vga_b} <= vga_in;
    end else begin
      {vga_r, vga_g, vga_b} <= 24'd0;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing on a shrunken raster (16 x 10 clocks per frame) so 256 frames fit in a short run.
module tb_vga_timing;

  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VV = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int PL = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

`ifdef VGA_TIMING_PIPE_ALIGN_EN
  localparam int SD = PL + 1;
  localparam int GD = PL;
`else
  localparam int SD = 1;
  localparam int GD = 1;
`endif

  logic        vga_clk;
  logic        reset;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [23:0] vga_in;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        hsync_n;
  logic        vsync_n;
  logic        blank_n;
  logic        next_frame;
  logic [7:0]  frame_count;

  vga_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIPE_LAT(PL)
  ) dut (
    .vga_clk(vga_clk),
    .reset(reset),
    .x_pos(x_pos),
    .y_pos(y_pos),
    .vga_in(vga_in),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .hsync_n(hsync_n),
    .vsync_n(vsync_n),
    .blank_n(blank_n),
    .next_frame(next_frame),
    .frame_count(frame_count)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // n = clocks since reset release; hs/vs/act are raw values at n, checked on the outputs at n+SD
  typedef struct {
    string name;
    int    n;
    int    x;
    int    y;
    int    hs;
    int    vs;
    int    act;
    int    nf;
    int    fc;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp_v);
    end
  endtask

  task automatic add(input string name, input int n, input int x, input int y, input int hs,
                     input int vs, input int act, input int nf, input int fc);
    vec_t e;
    e.name = name; e.n = n; e.x = x; e.y = y; e.hs = hs;
    e.vs = vs; e.act = act; e.nf = nf; e.fc = fc;
    tbl.push_back(e);
  endtask

  function automatic int act_at(input int k);
    if (k < 0) return 0;
    return (((k % HT) < HV) && (((k / HT) % VT) < VV)) ? 1 : 0;
  endfunction

  function automatic int fc_at(input int n);
    if (n < VV * HT) return 0;
    return (((n - VV * HT) / FRAME) + 1) % 256;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_x"}, x_pos, 0);
    check({tag, "_y"}, y_pos, 0);
    check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    check({tag, "_hsync_n"}, hsync_n, 1);
    check({tag, "_vsync_n"}, vsync_n, 1);
    check({tag, "_blank_n"}, blank_n, 0);
    check({tag, "_next_frame"}, next_frame, 0);
    check({tag, "_frame_count"}, frame_count, 0);
  endtask

  // Runs clocks 0..n_end after a reset release; ff_tail makes vga_in constant FFFFFF from the second frame on
  task automatic run(input int n_end, input bit ff_tail);
    logic [23:0] vin;
    logic [23:0] prev_vin;
    logic [23:0] exp_rgb;
    int          hs_low;
    int          vs_low;
    int          h;
    int          v;
    hs_low   = 0;
    vs_low   = 0;
    prev_vin = 24'd0;
    for (int n = 0; n <= n_end; n++) begin
      vin    = (ff_tail && n >= FRAME) ? 24'hFFFFFF : {8'(n), 8'(n * 7 + 1), 8'(~n)};
      vga_in = vin;
      h = n % HT;
      v = (n / HT) % VT;
      exp_rgb = (n == 0 || act_at(n - 1 - GD) == 0) ? 24'd0 : prev_vin;
      check("rgb", {vga_r, vga_g, vga_b}, exp_rgb);
      check("next_frame", next_frame, (h == 0 && v == VV) ? 1 : 0);
      check("frame_count", frame_count, fc_at(n));
      foreach (tbl[i]) begin
        if (tbl[i].n == n) begin
          check({tbl[i].name, "_x"}, x_pos, tbl[i].x);
          check({tbl[i].name, "_y"}, y_pos, tbl[i].y);
          check({tbl[i].name, "_next_frame"}, next_frame, tbl[i].nf);
          check({tbl[i].name, "_frame_count"}, frame_count, tbl[i].fc);
        end
        if (tbl[i].n + SD == n) begin
          check({tbl[i].name, "_hsync_n"}, hsync_n, 1 - tbl[i].hs);
          check({tbl[i].name, "_vsync_n"}, vsync_n, 1 - tbl[i].vs);
          check({tbl[i].name, "_blank_n"}, blank_n, tbl[i].act);
        end
      end
      if (!hsync_n) begin
        hs_low++;
      end else if (hs_low != 0) begin
        check("hsync_width", hs_low, HS);
        hs_low = 0;
      end
      if (!vsync_n) begin
        vs_low++;
      end else if (vs_low != 0) begin
        check("vsync_width", vs_low, VS * HT);
        vs_low = 0;
      end
      prev_vin = vin;
      @(posedge vga_clk);
      #1;
    end
  endtask

  initial begin
    //   name          n      x   y  hs vs act nf fc
    add("line0_start", 0,     0,  0, 0, 0, 1, 0, 0);
    add("last_vis",    7,     7,  0, 0, 0, 1, 0, 0);
    add("first_blank", 8,     8,  0, 0, 0, 0, 0, 0);
    add("pre_hsync",   9,     9,  0, 0, 0, 0, 0, 0);
    add("hsync_first", 10,    10, 0, 1, 0, 0, 0, 0);
    add("hsync_last",  12,    12, 0, 1, 0, 0, 0, 0);
    add("post_hsync",  13,    13, 0, 0, 0, 0, 0, 0);
    add("line_end",    15,    15, 0, 0, 0, 0, 0, 0);
    add("line1_start", 16,    0,  1, 0, 0, 1, 0, 0);
    add("pre_vblank",  95,    15, 5, 0, 0, 0, 0, 0);
    add("vblank",      96,    0,  6, 0, 0, 0, 1, 1);
    add("post_pulse",  97,    1,  6, 0, 0, 0, 0, 1);
    add("vsync_first", 112,   0,  7, 0, 1, 0, 0, 1);
    add("vsync_hsync", 139,   11, 8, 1, 1, 0, 0, 1);
    add("post_vsync",  144,   0,  9, 0, 0, 0, 0, 1);
    add("frame_end",   159,   15, 9, 0, 0, 0, 0, 1);
    add("frame_wrap",  160,   0,  0, 0, 0, 1, 0, 1);
    add("pulse2",      256,   0,  6, 0, 0, 0, 1, 2);
    add("pre_pulse256", 40895, 15, 5, 0, 0, 0, 0, 255);
    add("pulse256",    40896, 0,  6, 0, 0, 0, 1, 0);

    reset  = 1'b1;
    vga_in = 24'hFFFFFF;
    repeat (5) @(posedge vga_clk);
    #1;
    check_reset("reset");
    reset = 1'b0;
    run(199, 1'b1);

    // mid-frame (line 2, pixel 8) with live colour and frame_count 1
    reset = 1'b1;
    @(posedge vga_clk);
    #1;
    check_reset("midframe_reset");
    reset = 1'b0;
    run(40900, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
